// File: rtl/matrix_load_sequencer.sv
// RMII receive front end for the matrix loader: parses tagged A/B frames and replays payload MSB-dibit-first.
// Optional tag checking is enabled by defining MATRIX_LOAD_SEQ_TAG_CHECK_EN.
module matrix_load_sequencer #(
  parameter int unsigned MATRIX_DIM   = 32,
  parameter int unsigned MIN_PREAMBLE = 4,
  parameter logic [7:0]  TAG_A        = 8'h0A,
  parameter logic [7:0]  TAG_B        = 8'h0B
) (
  input  logic       eth_refclk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  input  logic       loader_complete,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       loader_rst,
  output logic       matrix_sel,
  output logic       busy,
  output logic       error,
  output logic       done
);

  localparam int unsigned PAY_DIBITS = 4 * MATRIX_DIM * MATRIX_DIM;
  localparam int unsigned CNT_W      = $clog2(PAY_DIBITS);
  localparam int unsigned PRE_W      = $clog2(MIN_PREAMBLE + 1);

`ifdef MATRIX_LOAD_SEQ_TAG_CHECK_EN
  localparam bit TAG_CHECK = 1'b1;
`else
  localparam bit TAG_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_TAG, S_PAYLOAD, S_DRAIN, S_WAIT_LOADER, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [PRE_W-1:0]   pre_cnt, pre_cnt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [5:0]         sr, sr_n;
  logic [7:0]         byte_q, byte_q_n;
  logic [2:0]         rep_cnt, rep_cnt_n;
  logic               frame_ok, frame_ok_n;
  logic               axiov_n, loader_rst_n, matrix_sel_n, busy_n, error_n, done_n;
  logic [1:0]         axiod_n;
  logic [7:0]         byte_in;
  logic               tag_match;
  logic               abort;

  // Byte being completed by the current dibit (dibits arrive LSB-first)
  assign byte_in   = {rxd, sr};
  assign tag_match = (byte_in == (matrix_sel ? TAG_B : TAG_A));

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      cnt        <= '0;
      sr         <= '0;
      byte_q     <= '0;
      rep_cnt    <= '0;
      frame_ok   <= 1'b0;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      loader_rst <= 1'b0;
      matrix_sel <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pre_cnt    <= pre_cnt_n;
      cnt        <= cnt_n;
      sr         <= sr_n;
      byte_q     <= byte_q_n;
      rep_cnt    <= rep_cnt_n;
      frame_ok   <= frame_ok_n;
      axiov      <= axiov_n;
      axiod      <= axiod_n;
      loader_rst <= loader_rst_n;
      matrix_sel <= matrix_sel_n;
      busy       <= busy_n;
      error      <= error_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    pre_cnt_n    = pre_cnt;
    cnt_n        = cnt;
    sr_n         = sr;
    byte_q_n     = byte_q;
    rep_cnt_n    = rep_cnt;
    frame_ok_n   = frame_ok;
    axiov_n      = 1'b0;
    axiod_n      = 2'b00;
    loader_rst_n = 1'b0;
    matrix_sel_n = matrix_sel;
    busy_n       = busy;
    error_n      = 1'b0;
    done_n       = done;
    abort        = 1'b0;

    // Replay the captured byte MSB-dibit-first, independent of frame state
    if (rep_cnt != 3'd0) begin
      axiov_n   = 1'b1;
      rep_cnt_n = rep_cnt - 3'd1;
      case (rep_cnt)
        3'd4:    axiod_n = byte_q[7:6];
        3'd3:    axiod_n = byte_q[5:4];
        3'd2:    axiod_n = byte_q[3:2];
        default: axiod_n = byte_q[1:0];
      endcase
    end

    case (state)
      S_IDLE: begin
        if (crsdv && rxd == 2'b01) begin
          pre_cnt_n = PRE_W'(1);
          state_n   = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (!crsdv) begin
          state_n = S_IDLE;
        end else if (rxd == 2'b01) begin
          if (pre_cnt != '1) pre_cnt_n = pre_cnt + PRE_W'(1);
        end else if (rxd == 2'b11 && pre_cnt >= PRE_W'(MIN_PREAMBLE)) begin
          state_n = S_TAG;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end else begin
          state_n = S_DRAIN;
        end
      end
      S_TAG: begin
        if (!crsdv) begin
          abort = 1'b1;
        end else begin
          sr_n  = {rxd, sr[5:2]};
          cnt_n = cnt + CNT_W'(1);
          if (cnt[1:0] == 2'd3) begin
            if (!TAG_CHECK || tag_match) begin
              state_n = S_PAYLOAD;
              cnt_n   = '0;
            end else begin
              abort = 1'b1;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!crsdv) begin
          abort = 1'b1;
        end else begin
          sr_n  = {rxd, sr[5:2]};
          cnt_n = cnt + CNT_W'(1);
          if (cnt[1:0] == 2'd3) begin
            byte_q_n  = byte_in;
            rep_cnt_n = 3'd4;
          end
          if (cnt == CNT_W'(PAY_DIBITS - 1)) begin
            state_n    = S_DRAIN;
            frame_ok_n = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!crsdv) begin
          busy_n     = 1'b0;
          frame_ok_n = 1'b0;
          if (frame_ok && !matrix_sel) begin
            matrix_sel_n = 1'b1;
            state_n      = S_IDLE;
          end else if (frame_ok) begin
            state_n = S_WAIT_LOADER;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_WAIT_LOADER: begin
        if (loader_complete) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end
      S_DONE: begin
        done_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Malformed frame: re-arm the loader and restart from matrix A
    if (abort) begin
      state_n      = S_DRAIN;
      frame_ok_n   = 1'b0;
      matrix_sel_n = 1'b0;
      error_n      = 1'b1;
      loader_rst_n = 1'b1;
      rep_cnt_n    = 3'd0;
      axiov_n      = 1'b0;
      axiod_n      = 2'b00;
    end
  end

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer: drives RMII frames and checks the replayed dibit stream and control pulses.
module tb_matrix_load_sequencer;

  logic       eth_refclk;
  logic       rst;
  logic       crsdv;
  logic [1:0] rxd;
  logic       loader_complete;
  logic       axiov;
  logic [1:0] axiod;
  logic       loader_rst;
  logic       matrix_sel;
  logic       busy;
  logic       error;
  logic       done;

  matrix_load_sequencer dut (
    .eth_refclk      (eth_refclk),
    .rst             (rst),
    .crsdv           (crsdv),
    .rxd             (rxd),
    .loader_complete (loader_complete),
    .axiov           (axiov),
    .axiod           (axiod),
    .loader_rst      (loader_rst),
    .matrix_sel      (matrix_sel),
    .busy            (busy),
    .error           (error),
    .done            (done)
  );

  initial eth_refclk = 1'b0;
  always #5 eth_refclk = ~eth_refclk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_edge = 0;
  int pay_t0 = 0;

  // Driver-owned frame context read by the monitor
  int frame_id = 0;
  bit exp_pat  = 1'b0;

  // Monitor-owned counters
  int mon_frame = 0;
  int idx = 0;
  int v_cnt = 0, mis_cnt = 0, err_cnt = 0, lrst_cnt = 0, busy_cnt = 0;
  int v_at_err = 0;
  int first_v = 0;
  logic [7:0] b1_seq = 8'h00;

  always @(posedge eth_refclk) cyc <= cyc + 1;

  // Compare every valid dibit against byte k = k (or ~k), MSB dibit first
  always @(negedge eth_refclk) begin : mon
    int i_now;
    logic [7:0] eb;
    logic [1:0] e;
    i_now = (frame_id != mon_frame) ? 0 : idx;
    mon_frame <= frame_id;
    if (axiov) begin
      eb = 8'(i_now / 4);
      if (exp_pat) eb = ~eb;
      e = 2'(eb >> (2 * (3 - (i_now % 4))));
      if (axiod !== e) mis_cnt <= mis_cnt + 1;
      if (i_now == 0) first_v <= cyc;
      if (i_now >= 4 && i_now < 8) b1_seq <= {b1_seq[5:0], axiod};
      v_cnt <= v_cnt + 1;
      idx   <= i_now + 1;
    end else begin
      idx <= i_now;
    end
    if (error) begin
      err_cnt  <= err_cnt + 1;
      v_at_err <= v_cnt;
    end
    if (loader_rst) lrst_cnt <= lrst_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    else n_pass++;
  endtask

  task automatic send_dibit(input logic c, input logic [1:0] d);
    @(negedge eth_refclk);
    crsdv = c;
    rxd   = d;
    last_edge = cyc + 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int j = 0; j < 4; j++) send_dibit(1'b1, b[2*j +: 2]);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) send_dibit(1'b0, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge eth_refclk);
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00; loader_complete = 1'b0;
    repeat (2) @(negedge eth_refclk);
    rst = 1'b0;
    @(negedge eth_refclk);
  endtask

  // Frame: pre x 01, SFD, tag, nbytes payload, optional 4-byte FCS, then idle; rst_at >= 0 resets mid-payload
  task automatic send_frame(input int pre, input logic [7:0] tag, input bit inv,
                            input int nbytes, input bit fcs, input int rst_at);
    logic [7:0] b;
    frame_id++;
    exp_pat = inv;
    for (int j = 0; j < pre; j++) send_dibit(1'b1, 2'b01);
    send_dibit(1'b1, 2'b11);
    send_byte(tag);
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) begin
        @(negedge eth_refclk);
        rst = 1'b1; crsdv = 1'b1; rxd = 2'b01;
        @(negedge eth_refclk);
        check("rst_mid_outs", 32'({axiov, axiod, loader_rst, matrix_sel, busy, error, done}), 32'd0);
        rst = 1'b0; crsdv = 1'b0; rxd = 2'b00;
        idle(4);
        return;
      end
      b = 8'(i);
      if (inv) b = ~b;
      send_byte(b);
      if (i == 0) pay_t0 = last_edge - 3;
    end
    if (fcs) for (int j = 0; j < 4; j++) send_byte(8'hA5);
    idle(12);
  endtask

  // Full-length frame with stream, count and matrix_sel checks
  task automatic run_frame(input string nm, input logic [7:0] tag, input bit inv,
                           input int exp_v, input logic exp_sel);
    int v0, m0;
    v0 = v_cnt; m0 = mis_cnt;
    send_frame(7, tag, inv, 1024, 1'b1, -1);
    check({nm, "_axiov_cycles"}, 32'(v_cnt - v0), 32'(exp_v));
    check({nm, "_stream_errs"}, 32'(mis_cnt - m0), 32'd0);
    check({nm, "_matrix_sel"}, 32'(matrix_sel), 32'(exp_sel));
  endtask

  initial begin
    int v0, e0, l0, b0;
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00; loader_complete = 1'b0;

    // Reset state
    do_reset();
    check("reset_outs", 32'({axiov, axiod, loader_rst, matrix_sel, busy, error, done}), 32'd0);

    // Short preamble is ignored silently
    v0 = v_cnt; e0 = err_cnt; b0 = busy_cnt;
    send_frame(2, 8'h0A, 1'b0, 8, 1'b1, -1);
    check("short_pre_axiov", 32'(v_cnt - v0), 32'd0);
    check("short_pre_error", 32'(err_cnt - e0), 32'd0);
    check("short_pre_busy", 32'(busy_cnt - b0), 32'd0);
    check("short_pre_sel", 32'(matrix_sel), 32'd0);

    // Good A frame
    b0 = busy_cnt; e0 = err_cnt;
    run_frame("frame_a", 8'h0A, 1'b0, 4096, 1'b1);
    check("a_latency", 32'(first_v - pay_t0), 32'd4);
    check("a_byte1_order", 32'(b1_seq), 32'h01);
    check("a_busy_cycles", 32'(busy_cnt - b0), 32'd4117);
    check("a_no_error", 32'(err_cnt - e0), 32'd0);

    // Good B frame, then loader confirmation
    run_frame("frame_b", 8'h0B, 1'b1, 4096, 1'b1);
    check("b_byte1_order", 32'(b1_seq), 32'hFE);
    check("b_done_before", 32'(done), 32'd0);
    @(negedge eth_refclk);
    loader_complete = 1'b1;
    @(negedge eth_refclk);
    loader_complete = 1'b0;
    check("done_after_complete", 32'(done), 32'd1);

    // Frames after done are ignored
    v0 = v_cnt; b0 = busy_cnt;
    send_frame(7, 8'h0A, 1'b0, 1024, 1'b1, -1);
    check("post_done_axiov", 32'(v_cnt - v0), 32'd0);
    check("post_done_busy", 32'(busy_cnt - b0), 32'd0);
    check("post_done_done", 32'(done), 32'd1);

    // Carrier drop after 100 payload bytes aborts
    do_reset();
    v0 = v_cnt; e0 = err_cnt; l0 = lrst_cnt;
    send_frame(7, 8'h0A, 1'b0, 100, 1'b0, -1);
    check("abort_error_cycles", 32'(err_cnt - e0), 32'd1);
    check("abort_lrst_cycles", 32'(lrst_cnt - l0), 32'd1);
    check("abort_axiov_cycles", 32'(v_cnt - v0), 32'd396);
    check("abort_axiov_after", 32'(v_cnt - v_at_err), 32'd0);
    check("abort_sel", 32'(matrix_sel), 32'd0);
    run_frame("retry_a", 8'h0A, 1'b0, 4096, 1'b1);
    run_frame("retry_b", 8'h0B, 1'b1, 4096, 1'b1);
    @(negedge eth_refclk);
    loader_complete = 1'b1;
    @(negedge eth_refclk);
    loader_complete = 1'b0;
    check("retry_done", 32'(done), 32'd1);

    // Tag B while A is expected
    do_reset();
    e0 = err_cnt;
`ifdef MATRIX_LOAD_SEQ_TAG_CHECK_EN
    run_frame("bad_tag", 8'h0B, 1'b0, 0, 1'b0);
    check("bad_tag_error", 32'(err_cnt - e0), 32'd1);
`else
    run_frame("bad_tag", 8'h0B, 1'b0, 4096, 1'b1);
    check("bad_tag_error", 32'(err_cnt - e0), 32'd0);
`endif

    // Reset in the middle of a B frame, then a fresh A frame
    do_reset();
    run_frame("pre_rst_a", 8'h0A, 1'b0, 4096, 1'b1);
    send_frame(7, 8'h0B, 1'b1, 1024, 1'b1, 500);
    check("after_rst_sel", 32'(matrix_sel), 32'd0);
    run_frame("after_rst_a", 8'h0A, 1'b0, 4096, 1'b1);
    check("after_rst_a_byte1", 32'(b1_seq), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
